// File: rtl/cache_pkg.sv
// Shared types and helpers for the n-way multi-word instruction cache.
// Holds the FSM state encoding, a constant-safe clog2 and the address-field widths.
package cache_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_MISS   = 3'd2,
        ST_REFILL = 3'd3,
        ST_RESP   = 3'd4
    } state_e;

    localparam logic [1:0] SIZE_WORD = 2'b10;

    // Ceiling log2 with clog2(1) = 0.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic int offset_w(input int line_words);
        return clog2(line_words) + 2;
    endfunction

    function automatic int index_w(input int sets);
        return clog2(sets);
    endfunction

    function automatic int tag_w(input int sets, input int line_words);
        return 32 - index_w(sets) - offset_w(line_words);
    endfunction

endpackage

// File: rtl/i_cache_nway_mw_if.sv
// Core-side SRAM-like instruction port plus bridge-side refill port of the i-cache.
// The slave modport is the cache's view; master is the surrounding core/bridge view.
interface i_cache_nway_mw_if #(
    parameter int LINE_WORDS = 8
);
    logic                     cpu_inst_req;
    logic                     cpu_inst_wr;
    logic [1:0]               cpu_inst_size;
    logic [31:0]              cpu_inst_addr;
    logic [31:0]              cpu_inst_wdata;
    logic [31:0]              cpu_inst_rdata;
    logic                     cpu_inst_addr_ok;
    logic                     cpu_inst_data_ok;

    logic                     cache_inst_req;
    logic                     cache_inst_wr;
    logic [1:0]               cache_inst_size;
    logic [31:0]              cache_inst_addr;
    logic [31:0]              cache_inst_wdata;
    logic [LINE_WORDS*32-1:0] cache_inst_rdata;
    logic                     cache_inst_addr_ok;
    logic                     cache_inst_data_ok;

    modport slave (
        input  cpu_inst_req, cpu_inst_wr, cpu_inst_size, cpu_inst_addr, cpu_inst_wdata,
        output cpu_inst_rdata, cpu_inst_addr_ok, cpu_inst_data_ok,
        output cache_inst_req, cache_inst_wr, cache_inst_size, cache_inst_addr, cache_inst_wdata,
        input  cache_inst_rdata, cache_inst_addr_ok, cache_inst_data_ok
    );

    modport master (
        output cpu_inst_req, cpu_inst_wr, cpu_inst_size, cpu_inst_addr, cpu_inst_wdata,
        input  cpu_inst_rdata, cpu_inst_addr_ok, cpu_inst_data_ok,
        input  cache_inst_req, cache_inst_wr, cache_inst_size, cache_inst_addr, cache_inst_wdata,
        output cache_inst_rdata, cache_inst_addr_ok, cache_inst_data_ok
    );
endinterface

// File: rtl/icache_plru_tree.sv
// Combinational tree pseudo-LRU: updates a set's node bits for an access and names the victim.
// Node n (heap order, root = 1) lives in bit n-1; a 0 bit points the victim search left.
module icache_plru_tree
    import cache_pkg::*;
#(
    parameter int WAYS   = 2,
    parameter int WAY_W  = (WAYS > 1) ? clog2(WAYS) : 1,
    parameter int TREE_W = (WAYS > 1) ? WAYS - 1 : 1
) (
    input  logic [TREE_W-1:0] tree,
    input  logic [WAY_W-1:0]  way,
    output logic [TREE_W-1:0] tree_next,
    output logic [WAY_W-1:0]  victim
);
    localparam int LVL = clog2(WAYS);

    always_comb begin
        int node;
        tree_next = tree;
        victim    = '0;
        node      = 1;
        if (WAYS > 1) begin
            // Every node on the accessed path is flipped to point at the other subtree.
            for (int l = 0; l < LVL; l++) begin
                tree_next[node-1] = ~way[LVL-1-l];
                node = 2 * node + int'(way[LVL-1-l]);
            end
            node = 1;
            for (int l = 0; l < LVL; l++) begin
                node = 2 * node + int'(tree[node-1]);
            end
            victim = WAY_W'(node - WAYS);
        end
    end
endmodule

// File: rtl/i_cache_nway_mw.sv
// Set-associative read-only instruction cache, multi-word lines, one wide refill beat per miss.
// Optional hit/miss counters are compiled in when ICACHE_PERF_EN is defined.
module i_cache_nway_mw
    import cache_pkg::*;
#(
    parameter int WAYS       = 2,
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 8
) (
    input  logic clk,
    input  logic rst,
    i_cache_nway_mw_if.slave bus
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0] perf_hit_cnt,
    output logic [31:0] perf_miss_cnt
`endif
);
    localparam int OFFSET_W = offset_w(LINE_WORDS);
    localparam int INDEX_W  = index_w(SETS);
    localparam int TAG_W    = tag_w(SETS, LINE_WORDS);
    localparam int WORD_W   = OFFSET_W - 2;
    localparam int LINE_W   = LINE_WORDS * 32;
    localparam int WAY_W    = (WAYS > 1) ? clog2(WAYS) : 1;
    localparam int TREE_W   = (WAYS > 1) ? WAYS - 1 : 1;

    localparam logic [2:0] IDLE   = ST_IDLE;
    localparam logic [2:0] LOOKUP = ST_LOOKUP;
    localparam logic [2:0] MISS   = ST_MISS;
    localparam logic [2:0] REFILL = ST_REFILL;
    localparam logic [2:0] RESP   = ST_RESP;

    logic [2:0]        state;
    logic [31:0]       addr_q;
    logic [WAY_W-1:0]  victim_q;
    logic              valid_q [WAYS][SETS];
    logic [TREE_W-1:0] plru_q  [SETS];
    logic [TAG_W-1:0]  tag_q   [WAYS][SETS];
    logic [LINE_W-1:0] data_q  [WAYS][SETS];

    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;
    logic [WORD_W-1:0]  word;
    assign idx  = addr_q[OFFSET_W +: INDEX_W];
    assign tag  = addr_q[31 -: TAG_W];
    assign word = addr_q[OFFSET_W-1:2];

    logic             hit;
    logic             has_inv;
    logic [WAY_W-1:0] hit_way;
    logic [WAY_W-1:0] inv_way;

    // Descending scan leaves the lowest-index invalid way in inv_way.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        has_inv = 1'b0;
        inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[w][idx] && tag_q[w][idx] == tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_q[w][idx]) begin
                has_inv = 1'b1;
                inv_way = WAY_W'(w);
            end
        end
    end

    logic [WAY_W-1:0]  plru_way;
    logic [WAY_W-1:0]  access_way;
    logic [TREE_W-1:0] plru_next;
    assign access_way = (state == LOOKUP) ? hit_way : victim_q;

    icache_plru_tree #(
        .WAYS   (WAYS),
        .WAY_W  (WAY_W),
        .TREE_W (TREE_W)
    ) u_plru (
        .tree      (plru_q[idx]),
        .way       (access_way),
        .tree_next (plru_next),
        .victim    (plru_way)
    );

    logic              data_ok;
    logic [WAY_W-1:0]  rd_way;
    logic [LINE_W-1:0] rd_line;
    assign data_ok = (state == LOOKUP && hit) || (state == RESP);
    assign rd_way  = (state == RESP) ? victim_q : hit_way;
    assign rd_line = data_q[rd_way][idx];

    assign bus.cpu_inst_addr_ok = (state == IDLE) && bus.cpu_inst_req;
    assign bus.cpu_inst_data_ok = data_ok;
    assign bus.cpu_inst_rdata   = data_ok ? rd_line[{word, 5'b00000} +: 32] : 32'h0;
    assign bus.cache_inst_req   = (state == MISS);
    assign bus.cache_inst_addr  = (state == MISS) ? {tag, idx, {OFFSET_W{1'b0}}} : 32'h0;
    assign bus.cache_inst_wr    = 1'b0;
    assign bus.cache_inst_size  = SIZE_WORD;
    assign bus.cache_inst_wdata = 32'h0;

    logic unused_ok;
    assign unused_ok = ^{bus.cpu_inst_wr, bus.cpu_inst_size, bus.cpu_inst_wdata, addr_q[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            addr_q   <= '0;
            victim_q <= '0;
            for (int w = 0; w < WAYS; w++) begin
                for (int s = 0; s < SETS; s++) valid_q[w][s] <= 1'b0;
            end
            for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cpu_inst_req) begin
                        addr_q <= bus.cpu_inst_addr;
                        state  <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        plru_q[idx] <= plru_next;
                        state       <= IDLE;
                    end else begin
                        victim_q <= has_inv ? inv_way : plru_way;
                        state    <= MISS;
                    end
                end
                MISS: begin
                    if (bus.cache_inst_addr_ok) state <= REFILL;
                end
                REFILL: begin
                    if (bus.cache_inst_data_ok) begin
                        valid_q[victim_q][idx] <= 1'b1;
                        plru_q[idx]            <= plru_next;
                        state                  <= RESP;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Tag and line storage carry no reset; valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (state == REFILL && bus.cache_inst_data_ok) begin
            tag_q[victim_q][idx]  <= tag;
            data_q[victim_q][idx] <= bus.cache_inst_rdata;
        end
    end

`ifdef ICACHE_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_hit_cnt  <= '0;
            perf_miss_cnt <= '0;
        end else if (state == LOOKUP) begin
            if (hit && perf_hit_cnt != 32'hFFFF_FFFF)
                perf_hit_cnt <= perf_hit_cnt + 32'd1;
            if (!hit && perf_miss_cnt != 32'hFFFF_FFFF)
                perf_miss_cnt <= perf_miss_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_i_cache_nway_mw.sv
// Directed bench for i_cache_nway_mw: cold misses, hits, PLRU conflicts, backpressure, reset in REFILL.
// Counter checks are included when ICACHE_PERF_EN is defined.
module tb_i_cache_nway_mw;
    import cache_pkg::*;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    i_cache_nway_mw_if #(.LINE_WORDS(8)) bus ();

`ifdef ICACHE_PERF_EN
    logic [31:0] perf_hit;
    logic [31:0] perf_miss;
`endif

    i_cache_nway_mw #(
        .WAYS       (2),
        .SETS       (64),
        .LINE_WORDS (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef ICACHE_PERF_EN
        ,
        .perf_hit_cnt  (perf_hit),
        .perf_miss_cnt (perf_miss)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mkword(input logic [31:0] la, input int i);
        if (la == 32'hBFC0_0000) return 32'h1111_1111 * 32'(i + 1);
        return la ^ (32'(i) << 2) ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [255:0] mkline(input logic [31:0] la);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = mkword(la, i);
        return l;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.cpu_inst_req       = 1'b0;
        bus.cpu_inst_wr        = 1'b0;
        bus.cpu_inst_size      = 2'b10;
        bus.cpu_inst_addr      = '0;
        bus.cpu_inst_wdata     = '0;
        bus.cache_inst_rdata   = '0;
        bus.cache_inst_addr_ok = 1'b0;
        bus.cache_inst_data_ok = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One core read with an inline bridge model; ack_delay cycles of addr_ok backpressure.
    task automatic cpu_read(input logic [31:0] a, input int ack_delay,
                            output logic [31:0] data, output int lat, output int nreq,
                            output logic [31:0] line_a, output int bad);
        int          waited;
        bit          seen;
        bit          dnext;
        bit          got;
        logic [31:0] cur;
        data = '0; lat = -1; nreq = 0; line_a = '0; bad = 0;
        waited = 0; seen = 0; dnext = 0; got = 0; cur = '0;
        @(negedge clk);
        bus.cpu_inst_req  = 1'b1;
        bus.cpu_inst_addr = a;
        #1;
        if (bus.cpu_inst_addr_ok !== 1'b1) bad++;
        @(posedge clk);
        #1;
        bus.cpu_inst_req  = 1'b0;
        bus.cpu_inst_addr = '0;
        for (int c = 1; c <= 60 && !got; c++) begin
            @(negedge clk);
            if (bus.cpu_inst_addr_ok !== 1'b0) bad++;
            if (bus.cpu_inst_data_ok === 1'b1) begin
                data = bus.cpu_inst_rdata;
                lat  = c;
                got  = 1;
            end
            bus.cache_inst_addr_ok = 1'b0;
            bus.cache_inst_data_ok = 1'b0;
            if (dnext) begin
                bus.cache_inst_data_ok = 1'b1;
                bus.cache_inst_rdata   = mkline(line_a);
                dnext = 0;
            end
            if (bus.cache_inst_req === 1'b1) begin
                if (!seen) begin
                    seen   = 1;
                    cur    = bus.cache_inst_addr;
                    waited = 0;
                end else if (bus.cache_inst_addr !== cur) begin
                    bad++;
                end
                if (waited >= ack_delay) begin
                    bus.cache_inst_addr_ok = 1'b1;
                    nreq++;
                    line_a = cur;
                    dnext  = 1;
                    seen   = 0;
                end else begin
                    waited++;
                end
            end
        end
    endtask

    logic [31:0] seq_a [6] = '{32'h0000, 32'h0800, 32'h0000, 32'h1000, 32'h0800, 32'h0000};
    int          seq_n [6] = '{1, 1, 0, 1, 1, 1};
    logic [31:0] seq_d [6] = '{32'h5A5A0000, 32'h5A5A0800, 32'h5A5A0000,
                               32'h5A5A1000, 32'h5A5A0800, 32'h5A5A0000};

    logic [31:0] d;
    logic [31:0] la;
    int          lat;
    int          nreq;
    int          bad;

    initial begin
        rst = 1'b1;
        bus.cpu_inst_req       = 1'b0;
        bus.cpu_inst_wr        = 1'b0;
        bus.cpu_inst_size      = 2'b10;
        bus.cpu_inst_addr      = '0;
        bus.cpu_inst_wdata     = '0;
        bus.cache_inst_rdata   = '0;
        bus.cache_inst_addr_ok = 1'b0;
        bus.cache_inst_data_ok = 1'b0;
        @(negedge clk);
        check("rst_addr_ok",    32'(bus.cpu_inst_addr_ok), 32'd0);
        check("rst_data_ok",    32'(bus.cpu_inst_data_ok), 32'd0);
        check("rst_rdata",      bus.cpu_inst_rdata, 32'd0);
        check("rst_cache_req",  32'(bus.cache_inst_req), 32'd0);
        check("rst_cache_addr", bus.cache_inst_addr, 32'd0);
        check("rst_cache_wr",   32'(bus.cache_inst_wr), 32'd0);
        check("rst_cache_size", 32'(bus.cache_inst_size), 32'd2);
        check("rst_cache_wdata", bus.cache_inst_wdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        cpu_read(32'hBFC0_0000, 0, d, lat, nreq, la, bad);
        check("t1_miss_data",   d, 32'h1111_1111);
        check("t1_miss_refill", 32'(nreq), 32'd1);
        check("t1_miss_addr",   la, 32'hBFC0_0000);
        check("t1_miss_lat",    32'(lat), 32'd4);
        check("t1_miss_proto",  32'(bad), 32'd0);
        bus.cpu_inst_wr = 1'b1;
        cpu_read(32'hBFC0_0004, 0, d, lat, nreq, la, bad);
        bus.cpu_inst_wr = 1'b0;
        check("t1_hit_data",   d, 32'h2222_2222);
        check("t1_hit_lat",    32'(lat), 32'd1);
        check("t1_hit_refill", 32'(nreq), 32'd0);
        cpu_read(32'hBFC0_0010, 0, d, lat, nreq, la, bad);
        check("t1_hit2_data", d, 32'h5555_5555);
        check("t1_hit2_lat",  32'(lat), 32'd1);

        do_reset();
        cpu_read(32'hBFC0_001C, 0, d, lat, nreq, la, bad);
        check("t2_data",   d, 32'h8888_8888);
        check("t2_addr",   la, 32'hBFC0_0000);
        check("t2_refill", 32'(nreq), 32'd1);

        do_reset();
        for (int i = 0; i < 6; i++) begin
            cpu_read(seq_a[i], 0, d, lat, nreq, la, bad);
            check($sformatf("t3_refill_%0d", i), 32'(nreq), 32'(seq_n[i]));
            check($sformatf("t3_data_%0d", i), d, seq_d[i]);
        end
`ifdef ICACHE_PERF_EN
        check("t6_perf_hit",  perf_hit, 32'd1);
        check("t6_perf_miss", perf_miss, 32'd5);
`endif

        do_reset();
`ifdef ICACHE_PERF_EN
        check("t6_perf_hit_rst",  perf_hit, 32'd0);
        check("t6_perf_miss_rst", perf_miss, 32'd0);
`endif
        cpu_read(32'h0000_2044, 5, d, lat, nreq, la, bad);
        check("t4_refill", 32'(nreq), 32'd1);
        check("t4_proto",  32'(bad), 32'd0);
        check("t4_addr",   la, 32'h0000_2040);
        check("t4_data",   d, 32'h5A5A_2044);
        check("t4_lat",    32'(lat), 32'd9);

        do_reset();
        @(negedge clk);
        bus.cpu_inst_req  = 1'b1;
        bus.cpu_inst_addr = 32'h0000_3000;
        @(negedge clk);
        bus.cpu_inst_req  = 1'b0;
        @(negedge clk);
        check("t5_miss_req",  32'(bus.cache_inst_req), 32'd1);
        check("t5_miss_addr", bus.cache_inst_addr, 32'h0000_3000);
        bus.cache_inst_addr_ok = 1'b1;
        @(negedge clk);
        bus.cache_inst_addr_ok = 1'b0;
        check("t5_refill_req", 32'(bus.cache_inst_req), 32'd0);
        rst = 1'b1;
        #1;
        check("t5_rst_cache_req", 32'(bus.cache_inst_req), 32'd0);
        check("t5_rst_data_ok",   32'(bus.cpu_inst_data_ok), 32'd0);
        check("t5_rst_rdata",     bus.cpu_inst_rdata, 32'd0);
        check("t5_rst_size",      32'(bus.cache_inst_size), 32'd2);
        @(negedge clk);
        rst = 1'b0;
        bus.cache_inst_data_ok = 1'b1;
        bus.cache_inst_rdata   = mkline(32'hDEAD_0000);
        @(negedge clk);
        bus.cache_inst_data_ok = 1'b0;
        check("t5_stale_data_ok", 32'(bus.cpu_inst_data_ok), 32'd0);
        check("t5_stale_req",     32'(bus.cache_inst_req), 32'd0);
        cpu_read(32'h0000_3000, 0, d, lat, nreq, la, bad);
        check("t5_rereq_refill", 32'(nreq), 32'd1);
        check("t5_rereq_data",   d, 32'h5A5A_3000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
